// File: rtl/sum_seg_display.sv
// Four-digit multiplexed seven-segment display for a 4-bit adder.
// Digits (right to left): sum, carry-out, operand B, operand A. The
// decimal point on the B digit shows carry-in. A snapshot of the adder
// signals is taken on load. All outputs are registered.
module sum_seg_display #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    input  logic [3:0] sum,
    input  logic       c_out,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    // Segment pattern gfedcba, low = lit.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      a_q, b_q, sum_q;
    logic            cin_q, cout_q;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            tick;
    logic [3:0]      nib;

    // Prescaler/index next state and the display pattern for the current digit.
    always_comb begin
        tick  = (cnt_q == CntMax);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = tick ? idx_q + 2'd1 : idx_q;

        nib = sum_q;
        case (idx_q)
            2'd0:    nib = sum_q;
            2'd1:    nib = {3'b000, cout_q};
            2'd2:    nib = b_q;
            default: nib = a_q;
        endcase

        an_d  = ~(4'b0001 << idx_q);
        seg_d = hex7(nib);
        dp_d  = ~((idx_q == 2'd2) && cin_q);
    end

    // State and output registers; reset blanks the display and dominates load.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            a_q    <= 4'h0;
            b_q    <= 4'h0;
            sum_q  <= 4'h0;
            cin_q  <= 1'b0;
            cout_q <= 1'b0;
            an_q   <= 4'b1111;
            seg_q  <= 7'b1111111;
            dp_q   <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            if (load) begin
                a_q    <= a;
                b_q    <= b;
                sum_q  <= sum;
                cin_q  <= c_in;
                cout_q <= c_out;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: doc/sum_seg_display.md
SUM_SEG_DISPLAY -- requirements
Module: sum_seg_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range >= 2.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load  input  1  snapshot strobe; samples the operand/result inputs.
REQ-005 SHALL have port a  input  4  adder operand A.
REQ-006 SHALL have port b  input  4  adder operand B.
REQ-007 SHALL have port c_in  input  1  adder carry-in.
REQ-008 SHALL have port sum  input  4  adder SUM output.
REQ-009 SHALL have port c_out  input  1  adder carry-out.
REQ-010 SHALL have port an  output  4  digit anodes, active-low, an[3] leftmost.
REQ-011 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-013 SHALL hold a snapshot register {a,b,c_in,sum,c_out}, loaded at any edge with load=1 and reset=0, otherwise held.
REQ-014 SHALL run a prescaler counting 0..REFRESH_DIV-1 then wrapping to 0; tick = prescaler at REFRESH_DIV-1.
REQ-015 SHALL keep a 2-bit digit index that increments on tick, wrapping 3->0; sequence 0,1,2,3,0,...
REQ-016 SHALL map digits: 0 = hex(sum), 1 = hex({3'b000,c_out}), 2 = hex(b), 3 = hex(a); digits 1:0 show the 5-bit result.
REQ-017 SHALL drive dp low only while digit 2 is active and snapshot c_in=1; otherwise dp=1.
REQ-018 SHALL drive an with exactly one low bit = active digit: idx0 1110, idx1 1101, idx2 1011, idx3 0111.
REQ-019 SHALL register an, seg, dp: outputs reflect index and snapshot as of the previous edge (1-cycle latency).
REQ-020 SHALL encode hex (gfedcba, low = lit): 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
REQ-021 SHALL, on load and tick at the same edge, apply both; the next output shows the new digit with the new snapshot.
REQ-022 SHALL hold each an pattern exactly REFRESH_DIV cycles in steady state; load SHALL not disturb prescaler or index.
REQ-023 SHALL ignore inputs a, b, c_in, sum, c_out when load=0.

Reset
REQ-024 SHALL, at any edge with reset=1, clear prescaler, index and snapshot to 0 and drive an=1111, seg=1111111, dp=1; reset SHALL dominate load.
REQ-025 SHALL, at first edge with reset=0, output digit 0 of the cleared snapshot: an=1110, seg=1000000, dp=1.
REQ-026 SHALL behave identically for reset asserted mid-scan: blank on next edge, restart at digit 0 after release.

Verification (REFRESH_DIV=4)
REQ-027 SHALL cover reset held 3 cycles -> an=1111, seg=1111111, dp=1; release -> next edge an=1110, seg=1000000.
REQ-028 SHALL cover load a=3,b=4,c_in=0,sum=7,c_out=0 -> an 1110/seg 1111000, 1101/1000000, 1011/0011001, 0111/0110000, dp=1 throughout.
REQ-029 SHALL cover load a=10,b=15,c_in=0,sum=9,c_out=1 -> digit0 0010000, digit1 1111001, digit2 0001110, digit3 0001000.
REQ-030 SHALL cover load a=10,b=5,c_in=1,sum=0,c_out=1 -> dp=0 only while an=1011; digit0 1000000, digit1 1111001.
REQ-031 SHALL cover scan timing -> an sequence 1110,1101,1011,0111,1110, each held exactly 4 cycles; load pulsed on a tick edge -> new digit shows new data next edge.
REQ-032 SHALL cover reset asserted mid-scan at idx2 with load=1 -> next edge blank, snapshot 0; after release an=1110, seg=1000000.
